// File: rtl/game_pkg.sv
// Shared constants, state encoding and cell addressing for the connect-four controller.
package game_pkg;
  localparam int ROWS = 6;
  localparam int COLS = 7;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  typedef enum logic [1:0] {
    HUMAN    = 2'd0,
    AI_WAIT  = 2'd1,
    AI_APPLY = 2'd2,
    DONE     = 2'd3
  } state_t;

  // High-bit index of cell (row, col) in the packed grid; row 0 is the bottom row.
  function automatic int cellIdx(input int row, input int col, input int nCols);
    return row * 2 * nCols + 2 * nCols - 1 - 2 * col;
  endfunction
endpackage

// File: rtl/col_fallback.sv
// Finds the lowest-numbered column that still has room; flags when every column is full.
module col_fallback #(
  parameter int ROWS = game_pkg::ROWS,
  parameter int COLS = game_pkg::COLS
) (
  input  logic [COLS*3-1:0] i_counts,
  output logic [2:0]        o_col,
  output logic              o_none
);
  import game_pkg::*;

  // Scan downward so the last hit left standing is the lowest free column.
  always_comb begin
    o_col  = '0;
    o_none = 1'b1;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (i_counts[c*3 +: 3] < 3'(ROWS)) begin
        o_col  = 3'(c);
        o_none = 1'b0;
      end
    end
  end
endmodule

// File: rtl/game_ctrl.sv
// Connect-four game controller: hotseat or human-versus-engine play, with a
// timeout fallback for the engine and game-over detection on win or full board.
module game_ctrl #(
  parameter int TIMEOUT = 200,
  parameter int ROWS    = game_pkg::ROWS,
  parameter int COLS    = game_pkg::COLS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sw,
  input  logic                   btn_valid,
  input  logic [2:0]             btn_col,
  input  logic [1:0]             win_in,
  input  logic                   ai_move,
  input  logic [6:0]             ai_opt,
  output logic [ROWS*COLS*2-1:0] grid,
  output logic [COLS*3-1:0]      column_counts,
  output logic                   player,
  output logic                   turn,
  output logic                   illegal,
  output logic                   game_over
);
  import game_pkg::*;

  localparam int NCELLS = ROWS * COLS;

  state_t                r_state;
  logic [NCELLS*2-1:0]   r_grid;
  logic [COLS*3-1:0]     r_counts;
  logic [5:0]            r_total;
  logic [7:0]            r_waitCnt;
  logic [6:0]            r_aiOpt;
  logic                  r_useFallback;
  logic                  r_player;
  logic                  r_turn;
  logic                  r_illegal;
  logic                  r_gameOver;

  logic [2:0] w_fbCol;
  logic       w_fbNone;
  logic [2:0] w_btnCount;
  logic       w_btnOk;
  logic [6:0] w_btnIdx;
  logic [2:0] w_aiCol;
  logic [2:0] w_aiRow;
  logic       w_aiValid;
  logic [2:0] w_applyCol;
  logic [2:0] w_applyRow;
  logic       w_applyOk;
  logic [6:0] w_applyIdx;

  col_fallback #(.ROWS(ROWS), .COLS(COLS)) u_fallback (
    .i_counts (r_counts),
    .o_col    (w_fbCol),
    .o_none   (w_fbNone)
  );

  always_comb begin
    w_btnCount = '0;
    w_btnOk    = 1'b0;
    w_btnIdx   = '0;
    if (int'(btn_col) < COLS) begin
      w_btnCount = r_counts[int'(btn_col)*3 +: 3];
      w_btnOk    = w_btnCount < 3'(ROWS);
      w_btnIdx   = 7'(cellIdx(int'(w_btnCount), int'(btn_col), COLS));
    end
  end

  // An engine pick is honoured only if it names the next free cell of its column.
  always_comb begin
    w_aiCol   = 3'((2 * COLS - 1 - int'(r_aiOpt) % (2 * COLS)) / 2);
    w_aiRow   = 3'(int'(r_aiOpt) / (2 * COLS));
    w_aiValid = r_aiOpt[0] && (int'(r_aiOpt) < 2 * NCELLS) &&
                (r_counts[int'(w_aiCol)*3 +: 3] == w_aiRow);
    if (!r_useFallback && w_aiValid) begin
      w_applyCol = w_aiCol;
      w_applyRow = w_aiRow;
      w_applyOk  = 1'b1;
    end else begin
      w_applyCol = w_fbCol;
      w_applyRow = r_counts[int'(w_fbCol)*3 +: 3];
      w_applyOk  = !w_fbNone;
    end
    w_applyIdx = 7'(cellIdx(int'(w_applyRow), int'(w_applyCol), COLS));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= HUMAN;
      r_grid        <= {NCELLS{CELL_EMPTY}};
      r_counts      <= '0;
      r_total       <= '0;
      r_waitCnt     <= '0;
      r_aiOpt       <= '0;
      r_useFallback <= 1'b0;
      r_player      <= 1'b0;
      r_turn        <= 1'b0;
      r_illegal     <= 1'b0;
      r_gameOver    <= 1'b0;
    end else begin
      r_illegal <= 1'b0;
      // A reported win or a full board ends the game ahead of any pending move.
      if (r_state != DONE && (win_in != 2'b00 || r_total == 6'(NCELLS))) begin
        r_state    <= DONE;
        r_player   <= 1'b0;
        r_gameOver <= 1'b1;
      end else begin
        case (r_state)
          HUMAN: begin
            if (btn_valid) begin
              if (w_btnOk) begin
                r_grid[w_btnIdx -: 2]              <= r_turn ? CELL_P2 : CELL_P1;
                r_counts[int'(btn_col)*3 +: 3] <= w_btnCount + 3'd1;
                r_total                            <= r_total + 6'd1;
                r_turn                             <= ~r_turn;
                if (sw && !r_turn) begin
                  r_state   <= AI_WAIT;
                  r_player  <= 1'b1;
                  r_waitCnt <= '0;
                end
              end else begin
                r_illegal <= 1'b1;
              end
            end
          end
          AI_WAIT: begin
            if (!sw) begin
              r_state  <= HUMAN;
              r_player <= 1'b0;
            end else if (ai_move) begin
              r_aiOpt       <= ai_opt;
              r_useFallback <= 1'b0;
              r_state       <= AI_APPLY;
              r_player      <= 1'b0;
            end else if (int'(r_waitCnt) >= TIMEOUT) begin
              r_useFallback <= 1'b1;
              r_state       <= AI_APPLY;
              r_player      <= 1'b0;
            end else if (r_waitCnt != 8'hFF) begin
              r_waitCnt <= r_waitCnt + 8'd1;
            end
          end
          AI_APPLY: begin
            if (w_applyOk) begin
              r_grid[w_applyIdx -: 2]               <= CELL_P2;
              r_counts[int'(w_applyCol)*3 +: 3] <= w_applyRow + 3'd1;
              r_total                               <= r_total + 6'd1;
            end
            r_turn  <= 1'b0;
            r_state <= HUMAN;
          end
          DONE: begin
            r_player <= 1'b0;
          end
          default: r_state <= HUMAN;
        endcase
      end
    end
  end

  assign grid          = r_grid;
  assign column_counts = r_counts;
  assign player        = r_player;
  assign turn          = r_turn;
  assign illegal       = r_illegal;
  assign game_over     = r_gameOver;
endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: a fixed vector table, hand-built corner sequences and
// random play compared against an array-based board model.
module tb_game_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sw = 1'b0;
  logic        btn_valid = 1'b0;
  logic [2:0]  btn_col = '0;
  logic [1:0]  win_in = '0;
  logic        ai_move = 1'b0;
  logic [6:0]  ai_opt = '0;
  logic [83:0] grid;
  logic [20:0] column_counts;
  logic        player;
  logic        turn;
  logic        illegal;
  logic        game_over;

  int checks = 0;
  int errors = 0;

  int mBoard [6][7];
  int mCnt   [7];
  int mTurn;

  typedef struct {
    bit          isAi;
    logic [2:0]  col;
    logic [6:0]  opt;
    int          row;
    int          cc;
    logic [1:0]  expCell;
    logic [20:0] expCounts;
    bit          expTurn;
    bit          expPlayer;
    bit          expIllegal;
  } vec_t;

  vec_t vecs [9];

  game_ctrl #(.TIMEOUT(200), .ROWS(6), .COLS(7)) dut (
    .clk           (clk),
    .rst           (rst),
    .sw            (sw),
    .btn_valid     (btn_valid),
    .btn_col       (btn_col),
    .win_in        (win_in),
    .ai_move       (ai_move),
    .ai_opt        (ai_opt),
    .grid          (grid),
    .column_counts (column_counts),
    .player        (player),
    .turn          (turn),
    .illegal       (illegal),
    .game_over     (game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [83:0] modelGrid();
    logic [83:0] g;
    g = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        g[r*14 + 13 - 2*c -: 2] = 2'(mBoard[r][c]);
    return g;
  endfunction

  function automatic logic [20:0] modelCounts();
    logic [20:0] cc;
    cc = '0;
    for (int c = 0; c < 7; c++) cc[c*3 +: 3] = 3'(mCnt[c]);
    return cc;
  endfunction

  function automatic int fallbackCol();
    for (int c = 0; c < 7; c++) if (mCnt[c] < 6) return c;
    return -1;
  endfunction

  function automatic int pickLegal();
    int c;
    c = int'($urandom_range(0, 6));
    while (mCnt[c] >= 6) c = (c + 1) % 7;
    return c;
  endfunction

  task automatic modelReset();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++) mBoard[r][c] = 0;
    for (int c = 0; c < 7; c++) mCnt[c] = 0;
    mTurn = 0;
  endtask

  task automatic modelAi(input int opt, input bit timedOut);
    int c;
    int r;
    c = (13 - opt % 14) / 2;
    r = opt / 14;
    if (timedOut || opt % 2 == 0 || opt >= 84 || mCnt[c] != r) c = fallbackCol();
    if (c >= 0) begin
      mBoard[mCnt[c]][c] = 2;
      mCnt[c]++;
    end
    mTurn = 0;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, " grid"}, 128'(grid), 128'(modelGrid()));
    checkOutput({tag, " counts"}, 128'(column_counts), 128'(modelCounts()));
    checkOutput({tag, " turn"}, 128'(turn), 128'(mTurn));
  endtask

  // Drive one cycle of inputs from a negedge; returns at the following negedge.
  task automatic applyStimulus(input bit bv, input logic [2:0] col, input bit am, input logic [6:0] opt);
    btn_valid = bv;
    btn_col   = col;
    ai_move   = am;
    ai_opt    = opt;
    @(negedge clk);
    btn_valid = 1'b0;
    ai_move   = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  task automatic humanMove(input int col, input string tag);
    applyStimulus(1'b1, 3'(col), 1'b0, 7'd0);
    mBoard[mCnt[col]][col] = (mTurn == 1) ? 2 : 1;
    mCnt[col]++;
    mTurn ^= 1;
    checkAll(tag);
    checkOutput({tag, " player"}, 128'(player), 128'(sw && mTurn == 1));
    checkOutput({tag, " illegal"}, 128'(illegal), 128'(0));
  endtask

  task automatic aiMove(input int opt, input string tag);
    applyStimulus(1'b0, 3'd0, 1'b1, 7'(opt));
    @(negedge clk);
    modelAi(opt, 1'b0);
    checkAll(tag);
    checkOutput({tag, " player"}, 128'(player), 128'(0));
  endtask

  initial begin
    int idx;
    bit found;
    logic [83:0] gSnap;

    vecs[0] = '{1'b0, 3'd3, 7'd0,  0, 3, 2'b01, 21'h000200, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 3'd0, 7'd11, 0, 1, 2'b10, 21'h000208, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 3'd0, 7'd0,  0, 0, 2'b01, 21'h000209, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 3'd0, 7'd27, 1, 0, 2'b10, 21'h00020A, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 3'd7, 7'd0,  1, 0, 2'b10, 21'h00020A, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 3'd6, 7'd0,  0, 6, 2'b01, 21'h04020A, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 3'd0, 7'd85, 2, 0, 2'b10, 21'h04020B, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 3'd2, 7'd0,  0, 2, 2'b01, 21'h04024B, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 3'd0, 7'd12, 3, 0, 2'b10, 21'h04024C, 1'b0, 1'b0, 1'b0};

    // Reset state
    doReset();
    checkOutput("reset grid", 128'(grid), 128'(0));
    checkOutput("reset counts", 128'(column_counts), 128'(0));
    checkOutput("reset turn", 128'(turn), 128'(0));
    checkOutput("reset player", 128'(player), 128'(0));
    checkOutput("reset illegal", 128'(illegal), 128'(0));
    checkOutput("reset game_over", 128'(game_over), 128'(0));

    // Vector table against the engine
    sw = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].isAi) begin
        applyStimulus(1'b0, 3'd0, 1'b1, vecs[i].opt);
        @(negedge clk);
      end else begin
        applyStimulus(1'b1, vecs[i].col, 1'b0, 7'd0);
      end
      idx = vecs[i].row * 14 + 13 - 2 * vecs[i].cc;
      checkOutput($sformatf("vec%0d cell", i), 128'(grid[idx -: 2]), 128'(vecs[i].expCell));
      checkOutput($sformatf("vec%0d counts", i), 128'(column_counts), 128'(vecs[i].expCounts));
      checkOutput($sformatf("vec%0d turn", i), 128'(turn), 128'(vecs[i].expTurn));
      checkOutput($sformatf("vec%0d player", i), 128'(player), 128'(vecs[i].expPlayer));
      checkOutput($sformatf("vec%0d illegal", i), 128'(illegal), 128'(vecs[i].expIllegal));
    end

    // Full-column and out-of-range rejects, then engine timeout with column 0 full
    sw = 1'b0;
    doReset();
    for (int i = 0; i < 6; i++) humanMove(0, "fill0");
    for (int i = 0; i < 6; i++) humanMove(2, "fill2");
    applyStimulus(1'b1, 3'd2, 1'b0, 7'd0);
    checkOutput("full col illegal", 128'(illegal), 128'(1));
    checkAll("full col");
    @(negedge clk);
    checkOutput("full col pulse end", 128'(illegal), 128'(0));
    applyStimulus(1'b1, 3'd7, 1'b0, 7'd0);
    checkOutput("col7 illegal", 128'(illegal), 128'(1));
    checkAll("col7");
    @(negedge clk);
    checkOutput("col7 pulse end", 128'(illegal), 128'(0));

    sw = 1'b1;
    humanMove(3, "pre-timeout");
    repeat (199) @(negedge clk);
    checkOutput("no early fallback", 128'(column_counts), 128'(modelCounts()));
    checkOutput("still waiting", 128'(player), 128'(1));
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (column_counts !== modelCounts()) found = 1'b1;
    end
    checkOutput("timeout fired", 128'(found), 128'(1));
    modelAi(0, 1'b1);
    checkAll("timeout");
    checkOutput("timeout cell col1", 128'(grid[11:10]), 128'(2'b10));
    checkOutput("timeout player", 128'(player), 128'(0));

    // Random play against the engine, with stray buttons while it thinks
    doReset();
    sw = 1'b1;
    for (int i = 0; i < 12; i++) begin
      int c;
      int opt;
      humanMove(pickLegal(), $sformatf("rnd%0d human", i));
      if ($urandom_range(0, 1) == 1) begin
        gSnap = grid;
        applyStimulus(1'b1, 3'($urandom_range(0, 7)), 1'b0, 7'd0);
        checkOutput($sformatf("rnd%0d stray illegal", i), 128'(illegal), 128'(0));
        checkOutput($sformatf("rnd%0d stray grid", i), 128'(grid), 128'(gSnap));
        checkOutput($sformatf("rnd%0d stray player", i), 128'(player), 128'(1));
      end
      if ($urandom_range(0, 1) == 1) begin
        c = pickLegal();
        opt = mCnt[c] * 14 + 13 - 2 * c;
      end else begin
        opt = int'($urandom_range(0, 127));
      end
      aiMove(opt, $sformatf("rnd%0d ai opt%0d", i, opt));
    end

    // Engine abandoned when sw drops; P2 then moves by button
    doReset();
    sw = 1'b1;
    humanMove(5, "swdrop p1");
    sw = 1'b0;
    @(negedge clk);
    checkOutput("swdrop player", 128'(player), 128'(0));
    checkOutput("swdrop turn", 128'(turn), 128'(1));
    applyStimulus(1'b0, 3'd0, 1'b1, 7'd13);
    @(negedge clk);
    checkAll("swdrop ai ignored");
    humanMove(5, "swdrop p2");
    checkOutput("swdrop p2 cell", 128'(grid[17:16]), 128'(2'b10));

    // Reset while the engine is running
    sw = 1'b1;
    humanMove(1, "rst-wait");
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst-wait player", 128'(player), 128'(0));
    checkOutput("rst-wait grid", 128'(grid), 128'(0));
    rst = 1'b0;
    modelReset();

    // Hotseat game to a full board
    doReset();
    sw = 1'b0;
    for (int i = 0; i < 42; i++) humanMove(pickLegal(), $sformatf("hot%0d", i));
    checkOutput("full not yet over", 128'(game_over), 128'(0));
    @(negedge clk);
    checkOutput("full game_over", 128'(game_over), 128'(1));
    applyStimulus(1'b1, 3'd0, 1'b0, 7'd0);
    checkOutput("done btn no illegal", 128'(illegal), 128'(0));
    checkAll("done btn ignored");
    checkOutput("done player", 128'(player), 128'(0));
    doReset();
    checkOutput("post-game grid", 128'(grid), 128'(0));
    checkOutput("post-game counts", 128'(column_counts), 128'(0));
    checkOutput("post-game over", 128'(game_over), 128'(0));

    // Win report beats a same-cycle button
    win_in = 2'b01;
    applyStimulus(1'b1, 3'd4, 1'b0, 7'd0);
    win_in = 2'b00;
    checkOutput("win game_over", 128'(game_over), 128'(1));
    checkOutput("win btn not applied", 128'(column_counts), 128'(0));
    checkOutput("win grid", 128'(grid), 128'(0));
    applyStimulus(1'b1, 3'd4, 1'b0, 7'd0);
    checkOutput("win later btn", 128'(column_counts), 128'(0));
    checkOutput("win still over", 128'(game_over), 128'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
